// File: rtl/exec_ctrl_unit.sv
// K1 execution/control unit: ALU with double-width results, relative branch-target
// calculator and instruction-completion aggregator. Define ALU_DIV_EN to include the divider.
module exec_ctrl_unit #(
  parameter int MOD_SIZE  = 32,
  parameter int COUNTSIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              aluControl,
  input  logic                    aluEnable,
  input  logic [MOD_SIZE-1:0]     num1,
  input  logic [MOD_SIZE-1:0]     num2,
  output logic [2*MOD_SIZE-1:0]   output1,
  output logic [2*MOD_SIZE-1:0]   output2,
  output logic                    aluDone,
  input  logic [COUNTSIZE-1:0]    currentCount,
  input  logic [2:0]              programNum,
  input  logic                    branchControl,
  input  logic                    branchEnable,
  output logic [COUNTSIZE-1:0]    branchResult,
  output logic                    branchDone,
  input  logic                    jumpDone,
  input  logic                    memWriteDone1,
  input  logic                    memWriteDone2,
  output logic                    doneMuxResult
);

  localparam int RW = 2 * MOD_SIZE;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_MOVE = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_FIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_op;
  logic [MOD_SIZE-1:0]   r_num1, r_num2;
  logic                  w_accept, w_div_req, w_div_last;
  logic [RW-1:0]         w_a, w_b, w_res1, w_res2;

  // S_EXEC is the write-out cycle of a single-cycle op; a new op may be sampled there too.
  assign w_accept = aluEnable && ((r_state == S_IDLE) || (r_state == S_EXEC));

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(MOD_SIZE);

  logic [MOD_SIZE-1:0]   r_quo, r_dvs, r_rem;
  logic [CW-1:0]         r_cnt;
  logic [MOD_SIZE:0]     w_rem_sh;
  logic [MOD_SIZE-1:0]   w_rem_sub;
  logic                  w_fit;

  assign w_div_req  = (aluControl == OP_DIV);
  assign w_div_last = (r_cnt == CW'(MOD_SIZE - 1));

  // Restoring step; a zero divisor always "fits", giving all-ones quotient and remainder = num1.
  assign w_rem_sh  = {r_rem, r_quo[MOD_SIZE-1]};
  assign w_fit     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh[MOD_SIZE-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept && w_div_req) begin
      r_quo <= num1;
      r_dvs <= num2;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (r_state == S_DIV) begin
      r_quo <= {r_quo[MOD_SIZE-2:0], w_fit};
      r_rem <= w_fit ? w_rem_sub : w_rem_sh[MOD_SIZE-1:0];
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_div_req  = 1'b0;
  assign w_div_last = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_EXEC: begin
        if (w_accept) w_state_nxt = w_div_req ? S_DIV : S_EXEC;
        else          w_state_nxt = S_IDLE;
      end
      S_DIV:   if (w_div_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_a    = RW'(r_num1);
    w_b    = RW'(r_num2);
    w_res1 = '0;
    w_res2 = '0;
    case (r_op)
      OP_ADD:  w_res1 = w_a + w_b;
      OP_SUB:  w_res1 = w_a - w_b;
      OP_MUL:  w_res1 = w_a * w_b;
      OP_DIV:  w_res1 = '0;
      OP_AND:  w_res1 = w_a & w_b;
      OP_OR:   w_res1 = w_a | w_b;
      OP_XOR:  w_res1 = w_a ^ w_b;
      OP_MOVE: begin
        w_res1 = w_a;
        w_res2 = w_b;
      end
      default: w_res1 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_num1  <= '0;
      r_num2  <= '0;
      output1 <= '0;
      output2 <= '0;
      aluDone <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      aluDone <= 1'b0;
      if (w_accept) begin
        r_op   <= aluControl;
        r_num1 <= num1;
        r_num2 <= num2;
      end
      if (r_state == S_EXEC) begin
        output1 <= w_res1;
        output2 <= w_res2;
        aluDone <= 1'b1;
      end
`ifdef ALU_DIV_EN
      else if (r_state == S_FIN) begin
        output1 <= RW'(r_quo);
        output2 <= RW'(r_rem);
        aluDone <= 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branchResult <= '0;
      branchDone   <= 1'b0;
    end else begin
      branchDone <= branchEnable;
      if (branchEnable)
        branchResult <= currentCount + COUNTSIZE'(1)
                        + (branchControl ? COUNTSIZE'(programNum) : '0);
    end
  end

  // Sticky completion flags; our own branchDone counts as control-flow resolution.
  logic r_f_ctrl, r_f_w1, r_f_w2;
  logic w_ctrl, w_w1, w_w2;

  assign w_ctrl = r_f_ctrl | branchDone | jumpDone;
  assign w_w1   = r_f_w1 | memWriteDone1;
  assign w_w2   = r_f_w2 | memWriteDone2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_ctrl      <= 1'b0;
      r_f_w1        <= 1'b0;
      r_f_w2        <= 1'b0;
      doneMuxResult <= 1'b0;
    end else if (w_ctrl && w_w1 && w_w2) begin
      r_f_ctrl      <= 1'b0;
      r_f_w1        <= 1'b0;
      r_f_w2        <= 1'b0;
      doneMuxResult <= 1'b1;
    end else begin
      r_f_ctrl      <= w_ctrl;
      r_f_w1        <= w_w1;
      r_f_w2        <= w_w2;
      doneMuxResult <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Scoreboard bench for exec_ctrl_unit: stimulus pushes expected responses with their
// due cycle, a negedge monitor pops and compares whenever the DUT presents a done pulse.
module tb_exec_ctrl_unit;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  aluControl;
  logic        aluEnable;
  logic [31:0] num1, num2;
  logic [63:0] output1, output2;
  logic        aluDone;
  logic [7:0]  currentCount;
  logic [2:0]  programNum;
  logic        branchControl, branchEnable;
  logic [7:0]  branchResult;
  logic        branchDone;
  logic        jumpDone, memWriteDone1, memWriteDone2;
  logic        doneMuxResult;

  always #5 clk = ~clk;

  exec_ctrl_unit #(.MOD_SIZE(32), .COUNTSIZE(8)) dut (
    .clk(clk), .reset(reset),
    .aluControl(aluControl), .aluEnable(aluEnable), .num1(num1), .num2(num2),
    .output1(output1), .output2(output2), .aluDone(aluDone),
    .currentCount(currentCount), .programNum(programNum),
    .branchControl(branchControl), .branchEnable(branchEnable),
    .branchResult(branchResult), .branchDone(branchDone),
    .jumpDone(jumpDone), .memWriteDone1(memWriteDone1), .memWriteDone2(memWriteDone2),
    .doneMuxResult(doneMuxResult)
  );

  typedef struct {
    logic rst, ae; logic [2:0] op; logic [31:0] n1, n2;
    logic be, bc; logic [7:0] cc; logic [2:0] pn;
    logic jd, m1, m2;
  } stim_t;
  typedef struct { int cyc; logic [63:0] o1, o2; } alu_e_t;
  typedef struct { int cyc; logic [7:0] pc; } br_e_t;

  alu_e_t aq[$];
  br_e_t  bq[$];
  int     gq[$];

  int   cyc = 0;
  logic rst_edge = 1'b0;
  int   n_cmp = 0, n_fail = 0;

  // reference-model state
  int   alu_free = 0, div_start = -1000;
  bit   prev_be = 0, fc = 0, f1 = 0, f2 = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input int due);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: pulse due at cycle %0d not seen by cycle %0d", nm, due, cyc);
  endtask

  function automatic void alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] o1, output logic [63:0] o2);
    logic [63:0] xa, xb;
    xa = {32'd0, a};
    xb = {32'd0, b};
    o1 = '0;
    o2 = '0;
    case (op)
      3'd0: o1 = xa + xb;
      3'd1: o1 = xa - xb;
      3'd2: o1 = xa * xb;
      3'd3: if (DIV_EN) begin
              if (b == 0) begin o1 = 64'hFFFF_FFFF; o2 = xa; end
              else begin o1 = xa / xb; o2 = xa % xb; end
            end
      3'd4: o1 = xa & xb;
      3'd5: o1 = xa | xb;
      3'd6: o1 = xa ^ xb;
      default: begin o1 = xa; o2 = xb; end
    endcase
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom % 5)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  // Drive one cycle of stimulus and record what the DUT owes in response.
  task automatic apply(input stim_t s);
    alu_e_t ea;
    br_e_t  eb;
    int     t;
    reset = s.rst; aluEnable = s.ae; aluControl = s.op; num1 = s.n1; num2 = s.n2;
    branchEnable = s.be; branchControl = s.bc; currentCount = s.cc; programNum = s.pn;
    jumpDone = s.jd; memWriteDone1 = s.m1; memWriteDone2 = s.m2;
    if (s.rst) begin
      while (aq.size() > 0 && aq[aq.size()-1].cyc > cyc) aq.delete(aq.size()-1);
      while (bq.size() > 0 && bq[bq.size()-1].cyc > cyc) bq.delete(bq.size()-1);
      while (gq.size() > 0 && gq[gq.size()-1] > cyc) gq.delete(gq.size()-1);
      fc = 0; f1 = 0; f2 = 0; prev_be = 0;
      alu_free = cyc + 1; div_start = -1000;
    end else begin
      if (s.ae && cyc >= alu_free) begin
        alu_ref(s.op, s.n1, s.n2, ea.o1, ea.o2);
        if (DIV_EN && s.op == 3'd3) begin
          ea.cyc = cyc + 34; alu_free = cyc + 34; div_start = cyc;
        end else begin
          ea.cyc = cyc + 2; alu_free = cyc + 1;
        end
        aq.push_back(ea);
      end
      if (s.be) begin
        t = int'(s.cc) + 1 + (s.bc ? int'(s.pn) : 0);
        eb.cyc = cyc + 1;
        eb.pc  = 8'(t % 256);
        bq.push_back(eb);
      end
      fc = fc | s.jd | prev_be;
      f1 = f1 | s.m1;
      f2 = f2 | s.m2;
      if (fc && f1 && f2) begin
        gq.push_back(cyc + 1);
        fc = 0; f1 = 0; f2 = 0;
      end
      prev_be = s.be;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(idle_s());
  endtask

  logic [63:0] h1 = '0, h2 = '0;
  alu_e_t      m_a;
  br_e_t       m_b;
  int          m_g;

  always @(negedge clk) begin
    if (rst_edge) begin h1 = '0; h2 = '0; end
    if (aluDone !== 1'b0) begin
      if (aq.size() == 0) chk("alu_unexpected_done", 64'(aluDone), 64'd0);
      else begin
        m_a = aq.pop_front();
        chk("alu_latency", 64'(cyc), 64'(m_a.cyc));
        chk("alu_output1", output1, m_a.o1);
        chk("alu_output2", output2, m_a.o2);
        h1 = m_a.o1; h2 = m_a.o2;
      end
    end else begin
      chk("alu_hold1", output1, h1);
      chk("alu_hold2", output2, h2);
    end
    while (aq.size() > 0 && aq[0].cyc < cyc) begin m_a = aq.pop_front(); miss("alu_done_missing", m_a.cyc); end

    if (branchDone !== 1'b0) begin
      if (bq.size() == 0) chk("branch_unexpected_done", 64'(branchDone), 64'd0);
      else begin
        m_b = bq.pop_front();
        chk("branch_latency", 64'(cyc), 64'(m_b.cyc));
        chk("branch_result", 64'(branchResult), 64'(m_b.pc));
      end
    end
    while (bq.size() > 0 && bq[0].cyc < cyc) begin m_b = bq.pop_front(); miss("branch_done_missing", m_b.cyc); end

    if (doneMuxResult !== 1'b0) begin
      if (gq.size() == 0) chk("donemux_unexpected", 64'(doneMuxResult), 64'd0);
      else begin
        m_g = gq.pop_front();
        chk("donemux_cycle", 64'(cyc), 64'(m_g));
      end
    end
    while (gq.size() > 0 && gq[0] < cyc) begin m_g = gq.pop_front(); miss("donemux_missing", m_g); end
  end

  initial begin
    stim_t s;
    reset = 1'b1; aluEnable = 0; aluControl = 0; num1 = 0; num2 = 0;
    branchEnable = 0; branchControl = 0; currentCount = 0; programNum = 0;
    jumpDone = 0; memWriteDone1 = 0; memWriteDone2 = 0;
    @(posedge clk);
    #1;
    chk("reset_output1", output1, 64'd0);
    chk("reset_output2", output2, 64'd0);
    chk("reset_aluDone", 64'(aluDone), 64'd0);
    chk("reset_branchResult", 64'(branchResult), 64'd0);
    chk("reset_branchDone", 64'(branchDone), 64'd0);
    chk("reset_doneMux", 64'(doneMuxResult), 64'd0);
    s = idle_s(); s.rst = 1; apply(s);
    idle(1);

    // ALU directed cases
    s = idle_s(); s.ae = 1; s.op = 3'd0; s.n1 = 32'hFFFF_FFFF; s.n2 = 32'd1; apply(s); idle(3);
    s.op = 3'd3; s.n1 = 32'd100; s.n2 = 32'd7; apply(s); idle(36);
    s.n2 = 32'd0; apply(s); idle(36);
    s.n2 = 32'd7; apply(s); idle(9);
    s = idle_s(); s.rst = 1; apply(s); idle(40);
    s = idle_s(); s.ae = 1; s.op = 3'd2; s.n1 = 32'hFFFF_FFFF; s.n2 = 32'hFFFF_FFFF; apply(s); idle(2);
    s.op = 3'd7; s.n1 = 32'd5; s.n2 = 32'd9; apply(s); idle(2);
    s.op = 3'd1; s.n1 = 32'd3; s.n2 = 32'd5; apply(s); idle(2);

    // branch directed cases, back to back
    s = idle_s(); s.be = 1; s.cc = 8'd10; s.pn = 3'd3; s.bc = 1; apply(s);
    s.bc = 0; apply(s);
    s.cc = 8'd254; s.pn = 3'd7; s.bc = 1; apply(s); idle(3);

    // aggregator orderings from a clean state
    s = idle_s(); s.rst = 1; apply(s); idle(1);
    s = idle_s(); s.be = 1; apply(s); idle(1);
    s = idle_s(); s.m1 = 1; apply(s);
    s = idle_s(); s.m2 = 1; apply(s); idle(3);
    s = idle_s(); s.jd = 1; apply(s);
    s = idle_s(); s.m1 = 1; apply(s);
    s = idle_s(); s.m2 = 1; apply(s); idle(3);
    s = idle_s(); s.jd = 1; s.m1 = 1; s.m2 = 1; apply(s);
    apply(s); idle(3);

    // randomized traffic on all three units at once
    for (int i = 0; i < 3000; i++) begin
      s = idle_s();
      s.rst = ($urandom % 500 == 0);
      if (cyc >= alu_free && ($urandom % 3 == 0)) begin
        s.ae = 1; s.op = 3'($urandom); s.n1 = rop(); s.n2 = rop();
      end else if (cyc > div_start && cyc <= div_start + 30 && ($urandom % 6 == 0)) begin
        s.ae = 1; s.op = 3'($urandom); s.n1 = rop(); s.n2 = rop();
      end
      s.be = ($urandom % 3 == 0);
      s.bc = 1'($urandom);
      s.cc = 8'($urandom);
      s.pn = 3'($urandom);
      s.jd = ($urandom % 4 == 0);
      s.m1 = ($urandom % 4 == 0);
      s.m2 = ($urandom % 4 == 0);
      apply(s);
    end
    idle(40);

    if (aq.size() + bq.size() + gq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never presented, required 0",
               aq.size() + bq.size() + gq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
